// File: rtl/crc_net_pkg.sv
// Shared constants for the CRC network link (transmitter and receiver),
// the receiver FSM state type and a one-bit CRC-16-CCITT step.
package crc_net_pkg;

   localparam int          PKT_W     = 136;
   localparam logic [7:0]  SYNC_BYTE = 8'hD5;
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   // Lowest packet bit covered by the CRC; bits below it hold the CRC itself.
   localparam int          CRC_LO    = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_e;

   // One MSB-first LFSR step: shift left, fold the polynomial in when the
   // bit leaving the register differs from the incoming data bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Serial CRC-16-CCITT generator: one data bit per enabled clock.
// init reloads the seed and takes priority over en.
module crc16_serial
   import crc_net_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] r_crc;

   // CRC register: reseed on init, advance one bit on en.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values that existed before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc <= CRC_INIT;
      end else if (init) begin
         r_crc <= CRC_INIT;
      end else if (en) begin
         r_crc <= crc16_step(r_crc, din);
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/tx_receiver.sv
// Serial receiver for the CRC network link: synchronizes rx_line, samples
// one start bit, 136 data bits (MSB first) and a stop bit, then checks the
// sync byte and CRC-16 before strobing rx_valid.
// Optional macro RX_ERR_COUNT_EN adds the saturating err_count output.
module tx_receiver
   import crc_net_pkg::*;
#(
   parameter int BIT_CYCLES = 434
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_line,
   output logic [PKT_W-1:0] rx_packet,
   output logic             rx_valid,
   output logic             crc_ok,
   output logic             frame_err,
   output logic             rx_busy
`ifdef RX_ERR_COUNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   localparam int                BAUD_W   = $clog2(BIT_CYCLES);
   localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(BIT_CYCLES / 2 - 1);
   localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(BIT_CYCLES - 1);
   localparam logic [7:0]        LAST_BIT = 8'(PKT_W - 1);
   localparam logic [7:0]        CRC_BITS = 8'(PKT_W - CRC_LO);

   rx_state_e         r_state;
   rx_state_e         w_next_state;
   logic              r_sync1;
   logic              r_sync2;
   logic              r_sync3;
   logic              w_fall;
   logic [BAUD_W-1:0] r_baud;
   logic [7:0]        r_bit_cnt;
   logic [PKT_W-1:0]  r_shift;
   logic [PKT_W-1:0]  r_rx_packet;
   logic              r_rx_valid;
   logic              r_crc_ok;
   logic              r_frame_err;
   logic              w_tick;
   logic              w_start_frame;
   logic              w_shift_en;
   logic              w_crc_en;
   logic              w_accept;
   logic              w_reject;
   logic [15:0]       w_crc;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   // Reset to 1 so an idle-high line does not look like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= rx_line;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_fall = r_sync3 & ~r_sync2;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and per-cycle control strobes; samples happen when the baud
   // counter reaches half a bit (START) or a full bit (DATA/STOP).
   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_tick        = 1'b0;
      w_start_frame = 1'b0;
      w_shift_en    = 1'b0;
      w_accept      = 1'b0;
      w_reject      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_start_frame = 1'b1;
               w_next_state  = ST_START;
            end
         end
         ST_START: begin
            w_tick = (r_baud == HALF_M1);
            if (w_tick) begin
               // A high line at mid start bit was only a glitch.
               w_next_state = r_sync2 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            w_tick = (r_baud == FULL_M1);
            if (w_tick) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_next_state = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            w_tick = (r_baud == FULL_M1);
            if (w_tick) begin
               if (r_sync2) begin
                  w_accept     = 1'b1;
                  w_next_state = ST_IDLE;
               end else begin
                  w_reject     = 1'b1;
                  w_next_state = ST_WAIT_HIGH;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (r_sync2) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Baud counter: restarts on the start edge and after every sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud <= '0;
      end else if (w_start_frame || w_tick) begin
         r_baud <= '0;
      end else if (r_state == ST_START || r_state == ST_DATA ||
                   r_state == ST_STOP) begin
         r_baud <= r_baud + BAUD_W'(1);
      end
   end

   // Data bit counter: number of data bits sampled so far in this frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
      end else if (w_start_frame) begin
         r_bit_cnt <= '0;
      end else if (w_shift_en) begin
         r_bit_cnt <= r_bit_cnt + 8'd1;
      end
   end

   // Deserializer: first received bit ends up in the MSB.
   // NOTE: the shift register is deliberately not reset; it is only read
   // after all 136 bits of the current frame have been shifted in.
   always_ff @(posedge clk) begin
      if (w_shift_en) begin
         r_shift <= {r_shift[PKT_W-2:0], r_sync2};
      end
   end

   // Only the sync byte and payload feed the CRC, not the trailing CRC field.
   assign w_crc_en = w_shift_en && (r_bit_cnt < CRC_BITS);

   crc16_serial u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (w_start_frame),
      .en   (w_crc_en),
      .din  (r_sync2),
      .crc  (w_crc)
   );

   // Registered result strobes; packet and status only change on a good stop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_packet <= '0;
         r_rx_valid  <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= w_accept;
         r_frame_err <= w_reject;
         if (w_accept) begin
            r_rx_packet <= r_shift;
            r_crc_ok    <= (w_crc == r_shift[CRC_LO-1:0]) &&
                           (r_shift[PKT_W-1 -: 8] == SYNC_BYTE);
         end
      end
   end

   assign rx_packet = r_rx_packet;
   assign rx_valid  = r_rx_valid;
   assign crc_ok    = r_crc_ok;
   assign frame_err = r_frame_err;
   assign rx_busy   = (r_state != ST_IDLE);

`ifdef RX_ERR_COUNT_EN
   logic [7:0] r_err_count;

   // Error counter: bad stop bits plus frames that failed CRC/sync; sticks at 8'hFF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= 8'h00;
      end else if ((r_frame_err || (r_rx_valid && !r_crc_ok)) &&
                   (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'h01;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_tx_receiver.sv
// Bench for tx_receiver: drives whole frames onto rx_line and compares the
// strobes and packet against a byte-wise CRC model of the link protocol.
module tb_tx_receiver;

   localparam int         BC   = 8;
   localparam logic [7:0] SYNC = 8'hD5;

   logic         clk     = 1'b0;
   logic         rst     = 1'b0;
   logic         rx_line = 1'b1;
   logic [135:0] rx_packet;
   logic         rx_valid;
   logic         crc_ok;
   logic         frame_err;
   logic         rx_busy;
`ifdef RX_ERR_COUNT_EN
   logic [7:0]   err_count;
`endif

   int total = 0;
   int bad   = 0;

   // Monitor state, updated on falling edges.
   int cyc        = 0;
   int v_cnt      = 0;
   int f_cnt      = 0;
   int both_cnt   = 0;
   int v_last_cyc = 0;

   // Expected receiver state.
   logic [135:0] exp_pkt = '0;
   logic         exp_ok  = 1'b0;
   logic [7:0]   exp_err = 8'h00;

   tx_receiver #(.BIT_CYCLES(BC)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_line   (rx_line),
      .rx_packet (rx_packet),
      .rx_valid  (rx_valid),
      .crc_ok    (crc_ok),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
`ifdef RX_ERR_COUNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Count high cycles of each strobe; a one-cycle pulse counts exactly once.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         v_cnt      <= v_cnt + 1;
         v_last_cyc <= cyc;
      end
      if (frame_err === 1'b1) f_cnt <= f_cnt + 1;
      if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed=no finish required=finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [135:0] obs,
                        input logic [135:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // CRC-16-CCITT over 15 bytes, byte at a time, MSB first.
   function automatic logic [15:0] crc_model(input logic [119:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int b = 0; b < 15; b++) begin
         c = c ^ {d[119 - 8*b -: 8], 8'h00};
         for (int k = 0; k < 8; k++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   function automatic logic [135:0] make_pkt(input logic [7:0] s,
                                             input logic [111:0] p);
      logic [119:0] d;
      d = {s, p};
      return {d, crc_model(d)};
   endfunction

   function automatic logic model_ok(input logic [135:0] p);
      return (crc_model(p[135:16]) == p[15:0]) && (p[135:128] == SYNC);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [111:0] rand_payload();
      return {$urandom, $urandom, $urandom, 16'($urandom)};
   endfunction

   // Start bit, 136 bits MSB first, stop bit; abort_at >= 0 stops driving
   // just before that data bit.
   task automatic send_frame(input logic [135:0] pkt, input logic stop_val,
                             input int abort_at);
      rx_line = 1'b0;
      cycles(BC);
      for (int i = 0; i < 136; i++) begin
         if (i == abort_at) return;
         rx_line = pkt[135 - i];
         cycles(BC);
      end
      rx_line = stop_val;
      cycles(BC);
   endtask

   // Send a frame with a good stop bit and check the single rx_valid result.
   task automatic rx_frame(input string tag, input logic [135:0] pkt);
      int vc0;
      int fc0;
      vc0 = v_cnt;
      fc0 = f_cnt;
      send_frame(pkt, 1'b1, -1);
      exp_pkt = pkt;
      exp_ok  = model_ok(pkt);
      if (!exp_ok) exp_err = sat_inc(exp_err);
      check({tag, "_vcnt"}, 136'(v_cnt), 136'(vc0 + 1));
      check({tag, "_fcnt"}, 136'(f_cnt), 136'(fc0));
      check({tag, "_pkt"},  rx_packet,   exp_pkt);
      check({tag, "_ok"},   136'(crc_ok), 136'(exp_ok));
   endtask

   initial begin
      logic [111:0] base_pl;
      logic [135:0] pkt;
      int vc0;
      int fc0;
      int t1;
      int hi;
      int mode;

      // Reset
      #1 rst = 1'b1;
      cycles(3);
      check("rst_pkt",   rx_packet,       '0);
      check("rst_valid", 136'(rx_valid),  '0);
      check("rst_ok",    136'(crc_ok),    '0);
      check("rst_ferr",  136'(frame_err), '0);
      check("rst_busy",  136'(rx_busy),   '0);
`ifdef RX_ERR_COUNT_EN
      check("rst_errcnt", 136'(err_count), '0);
`endif
      rst = 1'b0;
      cycles(4);

      // Known good frame
      base_pl = 112'h0123_4567_89AB_CDEF_4567_89AB_CDEF;
      pkt = make_pkt(SYNC, base_pl);
      rx_frame("good", pkt);

      // Packet bit 60 flipped on the line: received, but CRC fails
      rx_frame("flip60", pkt ^ (136'd1 << 60));
      cycles(2);
`ifdef RX_ERR_COUNT_EN
      check("flip60_errcnt", 136'(err_count), 136'(exp_err));
`endif

      // Stop bit low, then line held low for 20 more bit times
      vc0 = v_cnt;
      fc0 = f_cnt;
      send_frame(make_pkt(SYNC, rand_payload()), 1'b0, -1);
      rx_line = 1'b0;
      cycles(20 * BC);
      exp_err = sat_inc(exp_err);
      check("stop0_fcnt", 136'(f_cnt),   136'(fc0 + 1));
      check("stop0_vcnt", 136'(v_cnt),   136'(vc0));
      check("stop0_pkt",  rx_packet,     exp_pkt);
      check("stop0_ok",   136'(crc_ok),  136'(exp_ok));
      check("stop0_busy", 136'(rx_busy), 136'(1));
`ifdef RX_ERR_COUNT_EN
      check("stop0_errcnt", 136'(err_count), 136'(exp_err));
`endif
      rx_line = 1'b1;
      cycles(4);
      check("stop0_idle",  136'(rx_busy), '0);
      check("stop0_fcnt2", 136'(f_cnt),   136'(fc0 + 1));

      // Two-clock low glitch on the idle line
      cycles(4);
      vc0 = v_cnt;
      fc0 = f_cnt;
      rx_line = 1'b0;
      cycles(2);
      rx_line = 1'b1;
      hi = 0;
      for (int i = 0; i < BC / 2 + 2; i++) begin
         cycles(1);
         if (rx_busy === 1'b1) hi++;
      end
      check("glitch_busy_seen",  136'(hi != 0), 136'(1));
      check("glitch_busy_clear", 136'(rx_busy), '0);
      check("glitch_vcnt",       136'(v_cnt),   136'(vc0));
      check("glitch_fcnt",       136'(f_cnt),   136'(fc0));
      cycles(2 * BC);

      // Back-to-back good frames with no idle gap
      rx_frame("b2b_a", make_pkt(SYNC, rand_payload()));
      t1 = v_last_cyc;
      rx_frame("b2b_b", make_pkt(SYNC, rand_payload()));
      check("b2b_spacing", 136'(v_last_cyc - t1), 136'(138 * BC));

      // Reset in the middle of data bit 70
      vc0 = v_cnt;
      send_frame(make_pkt(SYNC, rand_payload()), 1'b1, 70);
      cycles(BC / 2);
      rst = 1'b1;
      rx_line = 1'b1;
      cycles(1);
      exp_pkt = '0;
      exp_ok  = 1'b0;
      exp_err = 8'h00;
      check("midrst_pkt",   rx_packet,       '0);
      check("midrst_valid", 136'(rx_valid),  '0);
      check("midrst_ok",    136'(crc_ok),    '0);
      check("midrst_ferr",  136'(frame_err), '0);
      check("midrst_busy",  136'(rx_busy),   '0);
      check("midrst_vcnt",  136'(v_cnt),     136'(vc0));
`ifdef RX_ERR_COUNT_EN
      check("midrst_errcnt", 136'(err_count), '0);
`endif
      rst = 1'b0;
      cycles(4);
      rx_frame("postrst", make_pkt(SYNC, rand_payload()));

      // Random frames: clean, single-bit corruption, or wrong sync byte
      for (int n = 0; n < 4; n++) begin
         mode = $urandom_range(0, 2);
         case (mode)
            0:       pkt = make_pkt(SYNC, rand_payload());
            1:       pkt = make_pkt(SYNC, rand_payload()) ^
                           (136'd1 << $urandom_range(0, 135));
            default: pkt = make_pkt(SYNC ^ 8'($urandom_range(1, 255)),
                                    rand_payload());
         endcase
         rx_frame($sformatf("rand%0d_m%0d", n, mode), pkt);
         cycles($urandom_range(1, 3 * BC));
      end
      cycles(2);
`ifdef RX_ERR_COUNT_EN
      check("final_errcnt", 136'(err_count), 136'(exp_err));
`endif
      check("never_both", 136'(both_cnt), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
